qpu_dtcm_icb_arbt: RTL and testbench

QPU_DTCM_ICB_ARBT -- requirements
Module: qpu_dtcm_icb_arbt

---
 rtl/qpu_dtcm_icb_arbt.sv | 124 ++++++++++++
 tb/tb_qpu_dtcm_icb_arbt.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qpu_dtcm_icb_arbt.sv
`default_nettype none
// ============================================================================
// Module   : qpu_dtcm_icb_arbt
// Purpose  : Round-robin ICB arbiter, LSU (m0) and external (m1) to the DTCM.
// Revision : 1.0  initial release
// ============================================================================
module qpu_dtcm_icb_arbt #(
  parameter  int AW = 16,
  parameter  int DW = 32,
  localparam int MW = DW / 8
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic          m0_icb_cmd_read,
  input  logic [DW-1:0] m0_icb_cmd_wdata,
  input  logic [MW-1:0] m0_icb_cmd_wmask,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [DW-1:0] m0_icb_rsp_rdata,

  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic          m1_icb_cmd_read,
  input  logic [DW-1:0] m1_icb_cmd_wdata,
  input  logic [MW-1:0] m1_icb_cmd_wmask,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [DW-1:0] m1_icb_rsp_rdata,

  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic          s_icb_cmd_read,
  output logic [DW-1:0] s_icb_cmd_wdata,
  output logic [MW-1:0] s_icb_cmd_wmask,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [DW-1:0] s_icb_rsp_rdata,

  output logic          arbt_active,
  output logic          arbt_err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_owner;
  logic   r_rr_last;
  logic   r_err;

  logic   w_out_vld;
  logic   w_any_vld;
  logic   w_grant;
  logic   w_rsp_hs;
  logic   w_cmd_hs;
  logic   w_can_issue;

  assign w_out_vld = (r_state == BUSY);
  assign w_any_vld = m0_icb_cmd_valid | m1_icb_cmd_valid;

  // Contention goes to whoever was not served last; a lone requester always wins.
  assign w_grant = (m0_icb_cmd_valid & m1_icb_cmd_valid) ? ~r_rr_last : m1_icb_cmd_valid;

  assign s_icb_rsp_ready = w_out_vld & (r_owner ? m1_icb_rsp_ready : m0_icb_rsp_ready);
  assign w_rsp_hs        = s_icb_rsp_valid & s_icb_rsp_ready;
  assign w_can_issue     = ~w_out_vld | w_rsp_hs;

  assign s_icb_cmd_valid = w_any_vld & w_can_issue;
  assign s_icb_cmd_addr  = w_grant ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
  assign s_icb_cmd_read  = w_grant ? m1_icb_cmd_read  : m0_icb_cmd_read;
  assign s_icb_cmd_wdata = w_grant ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
  assign s_icb_cmd_wmask = w_grant ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
  assign w_cmd_hs        = s_icb_cmd_valid & s_icb_cmd_ready;

  assign m0_icb_cmd_ready = s_icb_cmd_ready & w_can_issue & ~w_grant;
  assign m1_icb_cmd_ready = s_icb_cmd_ready & w_can_issue &  w_grant;

  assign m0_icb_rsp_valid = s_icb_rsp_valid & w_out_vld & ~r_owner;
  assign m1_icb_rsp_valid = s_icb_rsp_valid & w_out_vld &  r_owner;
  assign m0_icb_rsp_rdata = s_icb_rsp_rdata;
  assign m1_icb_rsp_rdata = s_icb_rsp_rdata;

  assign arbt_active = w_any_vld | w_out_vld;
  assign arbt_err    = r_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cmd_hs) w_state_nxt = BUSY;
      BUSY:    if (w_rsp_hs && !w_cmd_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cmd_hs) begin
        r_owner   <= w_grant;
        r_rr_last <= w_grant;
      end
      // A response with nothing outstanding is dropped and flagged until reset.
      if (s_icb_rsp_valid && !w_out_vld) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qpu_dtcm_icb_arbt.sv
`default_nettype none
// ============================================================================
// Module   : tb_qpu_dtcm_icb_arbt
// Purpose  : Scoreboard bench for the DTCM ICB round-robin arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_qpu_dtcm_icb_arbt;

  typedef struct packed {
    logic [15:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_icb_cmd_valid, m0_icb_cmd_ready, m0_icb_cmd_read;
  logic [15:0] m0_icb_cmd_addr;
  logic [31:0] m0_icb_cmd_wdata, m0_icb_rsp_rdata;
  logic [3:0]  m0_icb_cmd_wmask;
  logic        m0_icb_rsp_valid, m0_icb_rsp_ready;
  logic        m1_icb_cmd_valid, m1_icb_cmd_ready, m1_icb_cmd_read;
  logic [15:0] m1_icb_cmd_addr;
  logic [31:0] m1_icb_cmd_wdata, m1_icb_rsp_rdata;
  logic [3:0]  m1_icb_cmd_wmask;
  logic        m1_icb_rsp_valid, m1_icb_rsp_ready;
  logic        s_icb_cmd_valid, s_icb_cmd_ready, s_icb_cmd_read;
  logic [15:0] s_icb_cmd_addr;
  logic [31:0] s_icb_cmd_wdata, s_icb_rsp_rdata;
  logic [3:0]  s_icb_cmd_wmask;
  logic        s_icb_rsp_valid, s_icb_rsp_ready;
  logic        arbt_active, arbt_err;

  qpu_dtcm_icb_arbt #(.AW(16), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_icb_cmd_valid(m0_icb_cmd_valid), .m0_icb_cmd_ready(m0_icb_cmd_ready),
    .m0_icb_cmd_addr(m0_icb_cmd_addr), .m0_icb_cmd_read(m0_icb_cmd_read),
    .m0_icb_cmd_wdata(m0_icb_cmd_wdata), .m0_icb_cmd_wmask(m0_icb_cmd_wmask),
    .m0_icb_rsp_valid(m0_icb_rsp_valid), .m0_icb_rsp_ready(m0_icb_rsp_ready),
    .m0_icb_rsp_rdata(m0_icb_rsp_rdata),
    .m1_icb_cmd_valid(m1_icb_cmd_valid), .m1_icb_cmd_ready(m1_icb_cmd_ready),
    .m1_icb_cmd_addr(m1_icb_cmd_addr), .m1_icb_cmd_read(m1_icb_cmd_read),
    .m1_icb_cmd_wdata(m1_icb_cmd_wdata), .m1_icb_cmd_wmask(m1_icb_cmd_wmask),
    .m1_icb_rsp_valid(m1_icb_rsp_valid), .m1_icb_rsp_ready(m1_icb_rsp_ready),
    .m1_icb_rsp_rdata(m1_icb_rsp_rdata),
    .s_icb_cmd_valid(s_icb_cmd_valid), .s_icb_cmd_ready(s_icb_cmd_ready),
    .s_icb_cmd_addr(s_icb_cmd_addr), .s_icb_cmd_read(s_icb_cmd_read),
    .s_icb_cmd_wdata(s_icb_cmd_wdata), .s_icb_cmd_wmask(s_icb_cmd_wmask),
    .s_icb_rsp_valid(s_icb_rsp_valid), .s_icb_rsp_ready(s_icb_rsp_ready),
    .s_icb_rsp_rdata(s_icb_rsp_rdata),
    .arbt_active(arbt_active), .arbt_err(arbt_err)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  cmd_t exp_cmd0[$];
  cmd_t exp_cmd1[$];
  rsp_t exp_rsp[$];

  // Reference model: one transaction in flight, owner, last-served master, error flag.
  bit   m_busy, m_owner, m_rr, m_err;
  bit   hs0, hs1, hs_cmd, hs_rsp;
  bit   sl_has;
  bit   sl_owner;
  int   sl_dly;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    bit   v0, v1, rh, can, g, exp_scv;
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge clk);
      hs0    = m0_icb_cmd_valid & m0_icb_cmd_ready;
      hs1    = m1_icb_cmd_valid & m1_icb_cmd_ready;
      hs_cmd = s_icb_cmd_valid & s_icb_cmd_ready;
      hs_rsp = s_icb_rsp_valid & s_icb_rsp_ready;
      if (chk_en) begin
        if (rst) begin
          m_busy = 0; m_owner = 0; m_rr = 1; m_err = 0;
        end
        v0 = m0_icb_cmd_valid;
        v1 = m1_icb_cmd_valid;
        rh = s_icb_rsp_valid & m_busy & (m_owner ? m1_icb_rsp_ready : m0_icb_rsp_ready);
        can = !m_busy || rh;
        g = (v0 && v1) ? !m_rr : v1;
        exp_scv = (v0 || v1) && can;
        chk("s_cmd_valid", s_icb_cmd_valid, exp_scv);
        chk("m0_cmd_ready", m0_icb_cmd_ready, s_icb_cmd_ready & can & !g);
        chk("m1_cmd_ready", m1_icb_cmd_ready, s_icb_cmd_ready & can & g);
        chk("s_rsp_ready", s_icb_rsp_ready, m_busy & (m_owner ? m1_icb_rsp_ready : m0_icb_rsp_ready));
        chk("m0_rsp_valid", m0_icb_rsp_valid, s_icb_rsp_valid & m_busy & !m_owner);
        chk("m1_rsp_valid", m1_icb_rsp_valid, s_icb_rsp_valid & m_busy & m_owner);
        chk("arbt_active", arbt_active, v0 | v1 | m_busy);
        chk("arbt_err", arbt_err, m_err);
        if (!rst) begin
          if (exp_scv && s_icb_cmd_ready) begin
            if ((g ? exp_cmd1.size() : exp_cmd0.size()) == 0) begin
              chk("cmd_queue_empty", 1, 0);
            end else begin
              c = g ? exp_cmd1.pop_front() : exp_cmd0.pop_front();
              chk(g ? "m1_cmd_payload" : "m0_cmd_payload",
                  {s_icb_cmd_addr, s_icb_cmd_read, s_icb_cmd_wdata, s_icb_cmd_wmask}, c);
            end
          end
          if ((m0_icb_rsp_valid && m0_icb_rsp_ready) || (m1_icb_rsp_valid && m1_icb_rsp_ready)) begin
            if (exp_rsp.size() == 0) begin
              chk("rsp_queue_empty", 1, 0);
            end else begin
              r = exp_rsp.pop_front();
              chk("rsp_owner_rdata", {m1_icb_rsp_valid, m1_icb_rsp_valid ? m1_icb_rsp_rdata : m0_icb_rsp_rdata}, r);
            end
          end
          if (s_icb_rsp_valid && !m_busy) m_err = 1;
          if (exp_scv && s_icb_cmd_ready) begin
            m_busy = 1; m_owner = g; m_rr = g;
          end else if (rh) begin
            m_busy = 0;
          end
        end
      end
    end
  end

  task automatic new_cmd(output cmd_t c);
    c.addr  = 16'($urandom);
    c.read  = 1'($urandom);
    c.wdata = $urandom;
    c.wmask = 4'($urandom);
  endtask

  // One cycle of master and slave stimulus, applied just after the rising edge.
  task automatic drive_cycle(input bit allow_new, input bit force_both);
    cmd_t c;
    @(posedge clk); #1;
    if (hs0) m0_icb_cmd_valid = 0;
    if (!m0_icb_cmd_valid && allow_new && (force_both || $urandom_range(0, 2) == 0)) begin
      new_cmd(c);
      {m0_icb_cmd_addr, m0_icb_cmd_read, m0_icb_cmd_wdata, m0_icb_cmd_wmask} = c;
      m0_icb_cmd_valid = 1;
      exp_cmd0.push_back(c);
    end
    if (hs1) m1_icb_cmd_valid = 0;
    if (!m1_icb_cmd_valid && allow_new && (force_both || $urandom_range(0, 2) == 0)) begin
      new_cmd(c);
      {m1_icb_cmd_addr, m1_icb_cmd_read, m1_icb_cmd_wdata, m1_icb_cmd_wmask} = c;
      m1_icb_cmd_valid = 1;
      exp_cmd1.push_back(c);
    end
    m0_icb_rsp_ready = $urandom_range(0, 3) != 0;
    m1_icb_rsp_ready = $urandom_range(0, 3) != 0;
    s_icb_cmd_ready  = $urandom_range(0, 3) != 0;
    if (hs_rsp) begin
      s_icb_rsp_valid = 0;
      sl_has = 0;
    end
    if (hs_cmd) begin
      sl_has   = 1;
      sl_dly   = $urandom_range(0, 2);
      sl_owner = m_owner;
    end
    if (sl_has && !s_icb_rsp_valid) begin
      if (sl_dly == 0) begin
        s_icb_rsp_rdata = $urandom;
        s_icb_rsp_valid = 1;
        exp_rsp.push_back({sl_owner, s_icb_rsp_rdata});
      end else begin
        sl_dly--;
      end
    end
  endtask

  initial begin
    bit done;
    rst = 1;
    {m0_icb_cmd_valid, m0_icb_cmd_read, m0_icb_rsp_ready} = '0;
    {m1_icb_cmd_valid, m1_icb_cmd_read, m1_icb_rsp_ready} = '0;
    m0_icb_cmd_addr = '0; m0_icb_cmd_wdata = '0; m0_icb_cmd_wmask = '0;
    m1_icb_cmd_addr = '0; m1_icb_cmd_wdata = '0; m1_icb_cmd_wmask = '0;
    s_icb_cmd_ready = 1; s_icb_rsp_valid = 0; s_icb_rsp_rdata = '0;
    sl_has = 0; sl_dly = 0; sl_owner = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Both masters request together first: m0 must win, then they alternate.
    drive_cycle(1, 1);
    for (int i = 0; i < 3000; i++) drive_cycle(1, 0);

    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      drive_cycle(0, 0);
      done = exp_cmd0.size() == 0 && exp_cmd1.size() == 0 && exp_rsp.size() == 0 &&
             !m0_icb_cmd_valid && !m1_icb_cmd_valid && !m_busy && !sl_has;
    end
    chk("drain_done", done, 1);

    // Reset during an outstanding read; the late response must flag an error.
    @(posedge clk); #1;
    chk_en = 0;
    s_icb_cmd_ready = 1;
    m0_icb_cmd_valid = 1; m0_icb_cmd_read = 1; m0_icb_cmd_addr = 16'h0010;
    @(negedge clk);
    chk("dir_cmd_issue", {s_icb_cmd_valid, m0_icb_cmd_ready, s_icb_cmd_addr}, {1'b1, 1'b1, 16'h0010});
    @(posedge clk); #1;
    m0_icb_cmd_valid = 0;
    rst = 1;
    @(negedge clk);
    chk("dir_rst_drop", {arbt_active, s_icb_rsp_ready, arbt_err}, 3'b000);
    @(posedge clk); #1;
    rst = 0;
    s_icb_rsp_valid = 1; s_icb_rsp_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("dir_unsolicited_fwd", {m0_icb_rsp_valid, m1_icb_rsp_valid, s_icb_rsp_ready}, 3'b000);
    @(posedge clk); #1;
    s_icb_rsp_valid = 0;
    repeat (4) @(negedge clk);
    chk("dir_err_sticky", arbt_err, 1);
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("dir_err_cleared", arbt_err, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
